// File: rtl/reg_bank16_if.sv
// Write and clear handshake bundle for the 16-entry register bank.
// The master drives requests; the slave (the bank) returns status pulses.
interface reg_bank16_if;
  logic        iWe;
  logic [3:0]  iWaddr;
  logic [31:0] iWdata;
  logic [3:0]  iBe;
  logic        iClrReq;
  logic        oBusy;
  logic        oClrDone;
  logic        oWrErr;

  modport master (
    output iWe, iWaddr, iWdata, iBe, iClrReq,
    input  oBusy, oClrDone, oWrErr
  );

  modport slave (
    input  iWe, iWaddr, iWdata, iBe, iClrReq,
    output oBusy, oClrDone, oWrErr
  );
endinterface

// File: rtl/reg_bank16.sv
// 16 x 32-bit register bank with byte-masked writes and a
// sequential clear that zeroes one entry per cycle.
module reg_bank16 (
  input  logic        clk,
  input  logic        rst,
  reg_bank16_if.slave bus,
  output logic [31:0] oData1,
  output logic [31:0] oData2,
  output logic [31:0] oData3,
  output logic [31:0] oData4,
  output logic [31:0] oData5,
  output logic [31:0] oData6,
  output logic [31:0] oData7,
  output logic [31:0] oData8,
  output logic [31:0] oData9,
  output logic [31:0] oData10,
  output logic [31:0] oData11,
  output logic [31:0] oData12,
  output logic [31:0] oData13,
  output logic [31:0] oData14,
  output logic [31:0] oData15,
  output logic [31:0] oData16
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_ptr;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_mem [16];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int i = 0; i < 16; i++)
        r_mem[i] <= 32'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.iClrReq) begin
            r_state <= CLEAR;
            r_ptr   <= 4'd0;
            r_busy  <= 1'b1;
            r_err   <= bus.iWe;
          end else if (bus.iWe) begin
            for (int k = 0; k < 4; k++)
              if (bus.iBe[k])
                r_mem[bus.iWaddr][8*k +: 8]
                  <= bus.iWdata[8*k +: 8];
          end
        end
        CLEAR: begin
          r_mem[r_ptr] <= 32'd0;
          r_ptr        <= r_ptr + 4'd1;
          r_err        <= bus.iWe;
          if (r_ptr == 4'd15) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
          end
        end
        DONE: begin
          // Pulse is registered out of DONE, landing one cycle later.
          r_state <= IDLE;
          r_done  <= 1'b1;
          r_err   <= bus.iWe;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oBusy    = r_busy;
  assign bus.oClrDone = r_done;
  assign bus.oWrErr   = r_err;

  assign oData1  = r_mem[0];
  assign oData2  = r_mem[1];
  assign oData3  = r_mem[2];
  assign oData4  = r_mem[3];
  assign oData5  = r_mem[4];
  assign oData6  = r_mem[5];
  assign oData7  = r_mem[6];
  assign oData8  = r_mem[7];
  assign oData9  = r_mem[8];
  assign oData10 = r_mem[9];
  assign oData11 = r_mem[10];
  assign oData12 = r_mem[11];
  assign oData13 = r_mem[12];
  assign oData14 = r_mem[13];
  assign oData15 = r_mem[14];
  assign oData16 = r_mem[15];

endmodule

// File: tb/tb_reg_bank16.sv
// Bench for reg_bank16: directed and random steps checked against
// a cycle-count reference model of the bank and its clear sequence.
module tb_reg_bank16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_bank16_if bus ();
  logic [31:0] dout [16];

  reg_bank16 dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .oData1  (dout[0]),
    .oData2  (dout[1]),
    .oData3  (dout[2]),
    .oData4  (dout[3]),
    .oData5  (dout[4]),
    .oData6  (dout[5]),
    .oData7  (dout[6]),
    .oData8  (dout[7]),
    .oData9  (dout[8]),
    .oData10 (dout[9]),
    .oData11 (dout[10]),
    .oData12 (dout[11]),
    .oData13 (dout[12]),
    .oData14 (dout[13]),
    .oData15 (dout[14]),
    .oData16 (dout[15])
  );

  logic [31:0] m_mem [16];
  int          since;
  logic        e_busy;
  logic        e_done;
  logic        e_err;
  int          checks;
  int          errors;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // since: -1 when idle, else edges elapsed since the clear request.
  task automatic model(input logic we, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic clr, input logic r);
    if (r) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 32'd0;
      since  = -1;
      e_busy = 1'b0;
      e_done = 1'b0;
      e_err  = 1'b0;
    end else begin
      e_done = 1'b0;
      e_err  = 1'b0;
      if (since < 0) begin
        if (clr) begin
          since = 0;
          e_err = we;
        end else if (we) begin
          for (int k = 0; k < 4; k++)
            if (be[k]) m_mem[a][8*k +: 8] = d[8*k +: 8];
        end
      end else begin
        since++;
        e_err = we;
        if (since <= 16) m_mem[since-1] = 32'd0;
        if (since == 17) begin
          e_done = 1'b1;
          since  = -1;
        end
      end
      e_busy = (since >= 0) && (since <= 15);
    end
  endtask

  task automatic step(input logic we, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      input logic clr, input logic r);
    rst         = r;
    bus.iWe     = we;
    bus.iWaddr  = a;
    bus.iWdata  = d;
    bus.iBe     = be;
    bus.iClrReq = clr;
    @(posedge clk);
    model(we, a, d, be, clr, r);
    #1;
    for (int i = 0; i < 16; i++)
      chk($sformatf("oData%0d", i + 1), dout[i], m_mem[i]);
    chk("oBusy", {31'd0, bus.oBusy}, {31'd0, e_busy});
    chk("oClrDone", {31'd0, bus.oClrDone}, {31'd0, e_done});
    chk("oWrErr", {31'd0, bus.oWrErr}, {31'd0, e_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int done_seen;
    checks = 0;
    errors = 0;
    since  = -1;
    for (int i = 0; i < 16; i++) m_mem[i] = 32'hx;
    e_busy = 1'bx;
    e_done = 1'bx;
    e_err  = 1'bx;
    @(negedge clk);

    step(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd9, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);

    step(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    chk("wr_full", dout[5], 32'hDEADBEEF);
    step(1'b1, 4'd5, 32'h11223344, 4'b0101, 1'b0, 1'b0);
    chk("wr_mask", dout[5], 32'hDE22BE44);
    step(1'b1, 4'd5, 32'h55555555, 4'b0000, 1'b0, 1'b0);
    chk("wr_nobe", dout[5], 32'hDE22BE44);

    for (int i = 0; i < 16; i++)
      step(1'b1, 4'(i), 32'(i), 4'hF, 1'b0, 1'b0);

    // Clear with a dropped write and a re-request mid-sequence.
    step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    done_seen = 0;
    for (int c = 1; c <= 19; c++) begin
      step(c == 3, 4'd3, 32'hCAFEF00D, 4'hF, c == 6, 1'b0);
      if (bus.oClrDone) begin
        done_seen++;
        chk("done_cycle", 32'(c), 32'd17);
      end
    end
    chk("done_count", 32'(done_seen), 32'd1);
    chk("entry3_after_clr", dout[3], 32'd0);

    step(1'b1, 4'd7, 32'h0BADC0DE, 4'hF, 1'b1, 1'b0);
    idle(18);

    for (int i = 0; i < 16; i++)
      step(1'b1, 4'(i), $urandom, 4'hF, 1'b0, 1'b0);
    step(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    idle(8);
    step(1'b1, 4'd1, 32'h12345678, 4'hF, 1'b1, 1'b1);
    chk("busy_after_rst", {31'd0, bus.oBusy}, 32'd0);
    step(1'b1, 4'd2, 32'hA5A5A5A5, 4'hF, 1'b0, 1'b0);
    chk("wr_after_rst", dout[2], 32'hA5A5A5A5);
    idle(20);

    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 79) == 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
